lumos_fixed_point_multiplier: RTL and testbench
===============================================

// Module: lumos_fixed_point_multiplier
// PURPOSE
// - Multi-cycle signed Q16.16 fixed-point multiplier for the LUMOS RV32I core (fixed-point register file datapath).
// - Builds a 32x32 product from one shared combinational 8x8 unsigned multiplier, reusing it for 16 cycles.
// - Driven by the core control FSM with an enable/busy/ready handshake. Result written back to the fixed_point register file.
// PARAMETERS
// - FRAC_BITS  16  fractional bits of the Q format. The result is the full product arithmetically shifted right by FRAC_BITS.
// PORTS
// - clk        in   1   single clock, rising-edge.
// - reset      in   1   asynchronous, active-low reset.
// - enable     in   1   start request. Sampled only in IDLE.
// - operand_1  in   32  two's-complement Q16.16 multiplicand.
// - operand_2  in   32  two's-complement Q16.16 multiplier.
// - busy       out  1   high while an operation is in progress (MUL or DONE).
// - ready      out  1   one-cycle pulse. result and overflow are valid while it is high.
// - result     out  32  product[FRAC_BITS+31:FRAC_BITS] of the signed 64-bit product.
// - overflow   out  1   product[63:FRAC_BITS+31] are not all equal.
// BEHAVIOUR
// - Reset (async, reset=0):
//   - state=IDLE, counter=0, accumulator=0, latched operands=0.
//   - busy=0, ready=0, result=0, overflow=0.
//   - Reset mid-operation aborts the operation with no result.
// - FSM IDLE -> MUL -> DONE -> IDLE:
//   - IDLE: if enable=1 at edge E0, latch |operand_1| and |operand_2| and sign = msb1^msb2. Clear the accumulator, counter=0, go to MUL.
//   - MUL, edge k = E1..E16 (counter c = k-1, 0..15):
//     - i = c[1:0], j = c[3:2].
//     - accumulator += (a_byte[i] * b_byte[j]) << 8*(i+j), with a_byte/b_byte the 8-bit slices of the latched magnitudes.
//     - At c=15 go to DONE.
//   - DONE: ready=1 for exactly one cycle, between edges E16 and E17.
//     - product = sign ? -accumulator : accumulator (64-bit).
//     - result and overflow are derived from product.
//     - The next edge returns to IDLE.
// - Latency: ready is high in the 16th cycle after the sampling edge. Throughput: one operation per 18 cycles (IDLE gap mandatory).
// - result/overflow hold their last values after ready falls until the next operation reaches DONE.
// - enable while busy=1 is ignored. Operand changes after E0 do not affect the result.
// - Magnitude of 0x80000000 is 0x80000000, treated as unsigned 2^31, so -32768.0 is handled exactly.
// - Rounding: truncation toward -inf (arithmetic shift of the signed product). No saturation; overflow only flags wrap.
// - Accumulator is 64-bit unsigned. Max magnitude sum (2^31)^2 fits without carry loss.
// - enable held high continuously: a new operation starts on the first edge in IDLE after DONE.
// STRUCTURE
// - Shared defines header: ENABLE/DISABLE, state encodings (IDLE/MUL/DONE), FRAC_BITS default.
// - One sub-module: multiplier_8x8, combinational (in 8, in 8, out 16), product = operand_1 * operand_2 unsigned.
//   - Implemented as an array multiplier of AND partial products and adders. No behavioural '*' operator.
// - Top module: FSM, 4-bit counter, byte muxes, shifter/accumulator, sign fix, overflow detect.
// TESTING
// - multiplier_8x8 exhaustive: all i,j in 0..255 with 1 ns settle -> product == i*j (e.g. 255*255 = 0xFE01, 0*x = 0).
// - 1.5 x 2.0: 0x00018000 * 0x00020000 -> result 0x00030000, overflow=0.
//   - ready pulses exactly 16 cycles after the enable edge; busy high for 17 cycles.
// - -1.5 x 2.0: 0xFFFE8000 * 0x00020000 -> 0xFFFD0000.
//   - -0.5 x -0.5: 0xFFFF8000 * 0xFFFF8000 -> 0x00004000.
//   - Smallest: 0x00000001 * 0x00000001 -> 0x00000000.
// - Overflow: 0x7FFF0000 * 0x7FFF0000 -> overflow=1, result 0x00010000 (truncated bits). 0x80000000 * 0x00010000 -> 0x80000000, overflow=0.
// - Handshake: assert enable again at cycle 5 with different operands -> ignored, first result unchanged.
//   - Change operands at cycle 3 -> result unchanged. Next operation starts only after IDLE.
// - Reset low at cycle 8 of MUL -> busy=0, ready=0, result=0 immediately (async).
//   - After release, 3.0 x 0.25 (0x00030000 * 0x00004000) -> 0x0000C000.

Source files
------------

// File: rtl/lumos_fixed_point_multiplier_pkg.sv
// lumos_fixed_point_multiplier_pkg: shared constants, state encoding and helpers for the Q16.16 multiplier
package lumos_fixed_point_multiplier_pkg;
  localparam logic ENABLE = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam int FRAC_BITS_DEFAULT = 16;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  function automatic logic [31:0] magnitude(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction
endpackage

// File: rtl/lumos_fixed_point_multiplier_multiplier_8x8.sv
// lumos_fixed_point_multiplier_multiplier_8x8: combinational unsigned 8x8 array multiplier
module lumos_fixed_point_multiplier_multiplier_8x8 (
  input  logic [7:0]  operand_1,
  input  logic [7:0]  operand_2,
  output logic [15:0] product
);
  // sum of AND partial products, each weighted by its multiplier bit position
  always_comb begin
    product = '0;
    for (int k = 0; k < 8; k++)
      product = product + (16'({8'b0, operand_1 & {8{operand_2[k]}}}) << k);
  end
endmodule

// File: rtl/lumos_fixed_point_multiplier.sv
// lumos_fixed_point_multiplier: multi-cycle signed Q16.16 multiplier built on one shared 8x8 multiplier
module lumos_fixed_point_multiplier
  import lumos_fixed_point_multiplier_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  output logic        busy,
  output logic        ready,
  output logic [31:0] result,
  output logic        overflow
);
  localparam int PW = 64 - FRAC_BITS;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [31:0] a_mag, b_mag;
  logic sign;
  logic [63:0] acc, acc_nxt, term;
  logic [7:0] a_byte, b_byte;
  logic [15:0] pp;
  logic [2:0] byte_pos;
  logic [PW-1:0] prod_sh;
  assign a_byte = 8'(a_mag >> {cnt[1:0], 3'b000});
  assign b_byte = 8'(b_mag >> {cnt[3:2], 3'b000});
  assign byte_pos = {1'b0, cnt[1:0]} + {1'b0, cnt[3:2]};
  assign term = {48'b0, pp} << {byte_pos, 3'b000};
  assign acc_nxt = acc + term;
  assign prod_sh = PW'((sign ? -acc_nxt : acc_nxt) >> FRAC_BITS);
  assign busy = (state != IDLE) ? ENABLE : DISABLE;
  assign ready = (state == DONE) ? ENABLE : DISABLE;
  lumos_fixed_point_multiplier_multiplier_8x8 u_mul (
    .operand_1(a_byte),
    .operand_2(b_byte),
    .product  (pp)
  );
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // next-state: start on enable in IDLE, 16 MUL cycles, one DONE cycle
  always_comb begin
    state_nxt = IDLE;
    state_nxt = (state == IDLE) ? ((enable == ENABLE) ? MUL : IDLE) :
                (state == MUL)  ? ((cnt == 4'hF) ? DONE : MUL) : IDLE;
  end
  // operand latch, byte-product accumulation and final sign fix into the held outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      acc <= '0;
      a_mag <= '0;
      b_mag <= '0;
      sign <= 1'b0;
      result <= '0;
      overflow <= 1'b0;
    end else if (state == IDLE && enable == ENABLE) begin
      a_mag <= magnitude(operand_1);
      b_mag <= magnitude(operand_2);
      sign <= operand_1[31] ^ operand_2[31];
      acc <= '0;
      cnt <= '0;
    end else if (state == MUL) begin
      acc <= acc_nxt;
      cnt <= cnt + 4'd1;
      if (cnt == 4'hF) begin
        result <= prod_sh[31:0];
        overflow <= !((&prod_sh[PW-1:31]) || !(|prod_sh[PW-1:31]));
      end
    end
endmodule

// File: tb/tb_lumos_fixed_point_multiplier.sv
// tb_lumos_fixed_point_multiplier: directed self-checking bench for the Q16.16 multiplier
module tb_lumos_fixed_point_multiplier;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [31:0] operand_1 = '0;
  logic [31:0] operand_2 = '0;
  logic busy, ready, overflow;
  logic [31:0] result;
  logic [7:0] ma, mb;
  logic [15:0] mp;
  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lumos_fixed_point_multiplier dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .operand_1(operand_1),
    .operand_2(operand_2),
    .busy     (busy),
    .ready    (ready),
    .result   (result),
    .overflow (overflow)
  );

  lumos_fixed_point_multiplier_multiplier_8x8 u_m8 (
    .operand_1(ma),
    .operand_2(mb),
    .product  (mp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    operand_1 = x;
    operand_2 = y;
    enable = 1'b1;
    step();
    enable = 1'b0;
  endtask

  task automatic op(input string tag, input logic [31:0] x, input logic [31:0] y,
                    input logic [31:0] er, input logic eo);
    start(x, y);
    chk({tag, " busy@0"}, 64'(busy), 64'd1);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk({tag, " busy"}, 64'(busy), 64'd1);
      chk({tag, " ready"}, 64'(ready), 64'(k == 16));
    end
    chk({tag, " result"}, 64'(result), 64'(er));
    chk({tag, " overflow"}, 64'(overflow), 64'(eo));
    step();
    chk({tag, " busy after"}, 64'(busy), 64'd0);
    chk({tag, " ready after"}, 64'(ready), 64'd0);
    chk({tag, " result hold"}, 64'(result), 64'(er));
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 256; j++) begin
        ma = 8'(i);
        mb = 8'(j);
        #1;
        chk("mul8x8", 64'(mp), 64'(i * j));
      end
    #2 reset = 1'b0;
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    step();
    op("1.5x2", 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1'b0);
    op("-1.5x2", 32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000, 1'b0);
    op("-0.5x-0.5", 32'hFFFF_8000, 32'hFFFF_8000, 32'h0000_4000, 1'b0);
    op("smallest", 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0);
    op("ovf", 32'h7FFF_0000, 32'h7FFF_0000, 32'h0001_0000, 1'b1);
    op("min", 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0);
    start(32'h0001_8000, 32'h0002_0000);
    step();
    step();
    operand_1 = 32'hFFFF_8000;
    operand_2 = 32'hFFFF_8000;
    step();
    step();
    enable = 1'b1;
    for (int k = 5; k <= 16; k++) begin
      step();
      chk("hs ready", 64'(ready), 64'(k == 16));
    end
    chk("hs result", 64'(result), 64'h0003_0000);
    step();
    chk("hs idle gap", 64'(busy), 64'd0);
    step();
    chk("hs restart", 64'(busy), 64'd1);
    enable = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("hs2 ready", 64'(ready), 64'(k == 16));
    end
    chk("hs2 result", 64'(result), 64'h0000_4000);
    step();
    start(32'h0001_8000, 32'h0002_0000);
    repeat (8) step();
    reset = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort ready", 64'(ready), 64'd0);
    chk("abort result", 64'(result), 64'd0);
    @(negedge clk) reset = 1'b1;
    step();
    chk("post abort idle", 64'(busy), 64'd0);
    op("3x0.25", 32'h0003_0000, 32'h0000_4000, 32'h0000_C000, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
